// File: rtl/led_pattern_gen.sv
// led_pattern_gen: per-channel LED pattern generator driven by a shared
// prescaler tick. Each channel is configured with a mode (OFF, ON, BLINK,
// HEARTBEAT) and a half-period in ticks through a one-cycle write port.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   cfg_valid  configuration write request
//   cfg_ready  write accepted when cfg_valid && cfg_ready (1 whenever rst=0)
//   cfg_ch     target channel
//   cfg_mode   00 OFF, 01 ON, 10 BLINK, 11 HEARTBEAT
//   cfg_half   half-period in ticks (0 behaves as 1)
//   cfg_err    one-cycle pulse after an accepted write to a channel >= N_CH
//   tick       one-cycle prescaler pulse (registered)
//   led        LED drive, bit i = channel i (registered)
//
// Configuration macro
//   LED_HEARTBEAT_EN  enables HEARTBEAT mode; when undefined mode 11 is
//                     stored but behaves as OFF and no phase logic exists.
module led_pattern_gen #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned PERIOD_W = 16,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half,
    output logic                cfg_err,
    output logic                tick,
    output logic [N_CH-1:0]     led
);

    localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W = $clog2(DIV);
`ifdef LED_HEARTBEAT_EN
    // The long heartbeat phase lasts 5*half ticks, so the counter needs 3 extra bits.
    localparam int unsigned CNT_W   = PERIOD_W + 3;
`else
    localparam int unsigned CNT_W   = PERIOD_W;
`endif

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_HB    = 2'b11
    } mode_t;

    // Prescaler state
    logic               r_run;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic               r_tick;
    logic               r_err;

    // Channel state
    mode_t               r_mode [N_CH];
    logic [PERIOD_W-1:0] r_half [N_CH];
    logic [CNT_W-1:0]    r_cnt  [N_CH];
    logic [N_CH-1:0]     r_led;

    mode_t               w_mode_nxt [N_CH];
    logic [PERIOD_W-1:0] w_half_nxt [N_CH];
    logic [CNT_W-1:0]    w_cnt_nxt  [N_CH];
    logic [CNT_W-1:0]    w_hlen     [N_CH];
    logic [N_CH-1:0]     w_led_nxt;
    logic [N_CH-1:0]     w_wr;

`ifdef LED_HEARTBEAT_EN
    logic [1:0]          r_phase     [N_CH];
    logic [1:0]          w_phase_nxt [N_CH];
    logic [CNT_W-1:0]    w_plen      [N_CH];
`endif

    // Writes are always accepted outside reset, so ready is just the reset qualifier.
    assign cfg_ready = ~rst;
    assign tick      = r_tick;
    assign cfg_err   = r_err;
    assign led       = r_led;

    // Prescaler next count; held at 0 on the first edge after reset release.
    always_comb begin
        w_presc_nxt = r_presc;
        if (r_run) begin
            w_presc_nxt = (r_presc == PRESC_W'(DIV - 1)) ? '0 : r_presc + PRESC_W'(1);
        end
    end

    // Prescaler, tick and error registers; tick mirrors count == DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == PRESC_W'(DIV - 1));
            r_err   <= cfg_valid && (32'(cfg_ch) >= N_CH);
        end
    end

    // Per-channel next state; a write to a channel overrides any tick that cycle.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_wr[i]       = cfg_valid && (cfg_ch == CH_W'(i));
            w_hlen[i]     = (r_half[i] == '0) ? CNT_W'(1) : CNT_W'(r_half[i]);
            w_mode_nxt[i] = r_mode[i];
            w_half_nxt[i] = r_half[i];
            w_cnt_nxt[i]  = r_cnt[i];
            w_led_nxt[i]  = r_led[i];
`ifdef LED_HEARTBEAT_EN
            w_phase_nxt[i] = r_phase[i];
            w_plen[i]      = (r_phase[i] == 2'd3) ? CNT_W'(5) * w_hlen[i] : w_hlen[i];
`endif
            if (w_wr[i]) begin
                w_mode_nxt[i] = mode_t'(cfg_mode);
                w_half_nxt[i] = cfg_half;
                w_cnt_nxt[i]  = '0;
`ifdef LED_HEARTBEAT_EN
                w_phase_nxt[i] = 2'd0;
                w_led_nxt[i]   = (cfg_mode != MODE_OFF);
`else
                w_led_nxt[i]   = (cfg_mode == MODE_ON) || (cfg_mode == MODE_BLINK);
`endif
            end else begin
                case (r_mode[i])
                    MODE_ON: begin
                        w_cnt_nxt[i] = '0;
                        w_led_nxt[i] = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (r_tick) begin
                            if (r_cnt[i] == w_hlen[i] - CNT_W'(1)) begin
                                w_cnt_nxt[i] = '0;
                                w_led_nxt[i] = ~r_led[i];
                            end else begin
                                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                            end
                        end
                    end
`ifdef LED_HEARTBEAT_EN
                    MODE_HB: begin
                        // Phases 0 and 2 are lit; phase 3 is the long 5*half gap.
                        if (r_tick) begin
                            if (r_cnt[i] == w_plen[i] - CNT_W'(1)) begin
                                w_cnt_nxt[i]   = '0;
                                w_phase_nxt[i] = r_phase[i] + 2'd1;
                                w_led_nxt[i]   = ~w_phase_nxt[i][0];
                            end else begin
                                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                            end
                        end
                    end
`endif
                    default: begin
                        w_cnt_nxt[i] = '0;
                        w_led_nxt[i] = 1'b0;
                    end
                endcase
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_mode[i] <= MODE_OFF;
                r_half[i] <= PERIOD_W'(1);
                r_cnt[i]  <= '0;
`ifdef LED_HEARTBEAT_EN
                r_phase[i] <= 2'd0;
`endif
            end
            r_led <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_mode[i] <= w_mode_nxt[i];
                r_half[i] <= w_half_nxt[i];
                r_cnt[i]  <= w_cnt_nxt[i];
`ifdef LED_HEARTBEAT_EN
                r_phase[i] <= w_phase_nxt[i];
`endif
            end
            r_led <= w_led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen: two instances (N_CH=4 and N_CH=3) share one
// configuration bus; a tick-count reference model predicts every output.
module tb_led_pattern_gen;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_half;

    logic        ready_a, err_a, tick_a;
    logic [3:0]  led_a;
    logic        ready_b, err_b, tick_b;
    logic [2:0]  led_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int       m_cyc;
    logic     m_tick;
    logic     m_err_b;
    int       m_mode [4];
    int       m_half [4];
    int       m_t    [4];

    led_pattern_gen #(.CLK_HZ(100), .TICK_HZ(10), .N_CH(4), .PERIOD_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half),
        .cfg_err(err_a), .tick(tick_a), .led(led_a)
    );

    led_pattern_gen #(.CLK_HZ(100), .TICK_HZ(10), .N_CH(3), .PERIOD_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half),
        .cfg_err(err_b), .tick(tick_b), .led(led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // LED level after t ticks since the last write, from the pattern definitions.
    function automatic logic exp_led(input int mode, input int half, input int t);
        int h;
        int pos;
        h = (half == 0) ? 1 : half;
        pos = 0;
        case (mode)
            1: return 1'b1;
            2: return ((t / h) % 2) == 0;
            3: begin
`ifdef LED_HEARTBEAT_EN
                pos = t % (8 * h);
                return (pos < h) || (pos >= 2 * h && pos < 3 * h);
`else
                return 1'b0;
`endif
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] exp_leds();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = exp_led(m_mode[c], m_half[c], m_t[c]);
        return v;
    endfunction

    // Advance the model across one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        if (rst) begin
            m_cyc   = 0;
            m_err_b = 1'b0;
            for (int c = 0; c < 4; c++) begin
                m_mode[c] = 0;
                m_half[c] = 1;
                m_t[c]    = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (cfg_valid && int'(cfg_ch) == c) begin
                    m_mode[c] = int'(cfg_mode);
                    m_half[c] = int'(cfg_half);
                    m_t[c]    = 0;
                end else if (m_tick) begin
                    m_t[c]++;
                end
            end
            m_err_b = cfg_valid && (cfg_ch == 2'd3);
            m_cyc++;
        end
        m_tick = !rst && (m_cyc >= 10) && (m_cyc % 10 == 0);
    endtask

    task automatic step();
        logic [3:0] e;
        @(posedge clk);
        model_edge();
        #1;
        e = exp_leds();
        check("led_a",   32'(led_a),   32'(e));
        check("led_b",   32'(led_b),   32'(e[2:0]));
        check("tick_a",  32'(tick_a),  32'(m_tick));
        check("tick_b",  32'(tick_b),  32'(m_tick));
        check("err_a",   32'(err_a),   32'(0));
        check("err_b",   32'(err_b),   32'(m_err_b));
        check("ready_a", 32'(ready_a), 32'(!rst));
        check("ready_b", 32'(ready_b), 32'(!rst));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input logic [1:0] ch, input logic [1:0] mode, input int half);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_half  = 16'(half);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int  waited;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_mode  = 2'd0;
        cfg_half  = 16'd0;
        m_cyc     = 0;
        m_tick    = 1'b0;
        m_err_b   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_mode[c] = 0;
            m_half[c] = 1;
            m_t[c]    = 0;
        end

        // Reset state, then release and watch the prescaler alone
        run(3);
        rst = 1'b0;
        run(25);

        // Blink on ch1, then more channels blinking
        write(2'd1, 2'd2, 3);
        run(70);
        write(2'd2, 2'd2, 2);
        write(2'd0, 2'd2, 4);
        run(45);

        // Override ch0 with ON in a tick cycle while ch2 keeps blinking
        waited = 0;
        while (!m_tick && waited < 20) begin
            step();
            waited++;
        end
        check("tick_wait", 32'(m_tick), 32'(1));
        write(2'd0, 2'd1, 5);
        run(40);

        // Heartbeat on ch3 (error pulse on the 3-channel instance)
        write(2'd3, 2'd3, 2);
        run(340);

        // Half of zero, OFF, and randomized writes
        write(2'd1, 2'd2, 0);
        run(30);
        write(2'd3, 2'd0, 7);
        run(5);
        for (int k = 0; k < 30; k++) begin
            write(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            run(int'($urandom_range(0, 40)));
        end

        // Asynchronous reset mid-blink
        write(2'd1, 2'd2, 3);
        run(5);
        #2;
        rst = 1'b1;
        #1;
        check("async_led_a",  32'(led_a),  32'(0));
        check("async_led_b",  32'(led_b),  32'(0));
        check("async_tick_a", 32'(tick_a), 32'(0));
        check("async_ready",  32'(ready_a), 32'(0));
        run(3);
        rst = 1'b0;
        run(25);
        write(2'd1, 2'd2, 1);
        run(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, prescaler tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, >= 2.
REQ-003 SHALL have parameter N_CH, default 4, number of LED channels, 1..16; CH_W = max(1, clog2(N_CH)).
REQ-004 SHALL have parameter PERIOD_W, default 16, width of the per-channel half-period field in ticks.
REQ-005 SHALL use one clock and an asynchronous, active-high reset:
- clk  input  1  system clock, all state on its rising edge
- rst  input  1  asynchronous, active-high reset
- cfg_valid  input  1  configuration write request
- cfg_ready  output  1  write accepted when cfg_valid && cfg_ready
- cfg_ch  input  CH_W  target channel
- cfg_mode  input  2  00 OFF, 01 ON, 10 BLINK, 11 HEARTBEAT
- cfg_half  input  PERIOD_W  half-period in ticks
- cfg_err  output  1  one-cycle pulse: accepted write with cfg_ch >= N_CH
- tick  output  1  one-cycle prescaler pulse
- led  output  N_CH  LED drive, bit i = channel i

Function
REQ-006 SHALL count the prescaler 0..DIV-1, wrapping to 0; tick SHALL be 1 exactly in the cycle where the count is DIV-1.
REQ-007 SHALL hold cfg_ready = 1 in every cycle rst is deasserted; every write SHALL complete in one cycle.
REQ-008 An accepted write SHALL update that channel's mode and half on the next edge, clear its phase counter and phase index, and set led[ch] to 1 for ON/BLINK/HEARTBEAT and to 0 for OFF.
REQ-009 An accepted write with cfg_ch >= N_CH SHALL change no channel state and SHALL pulse cfg_err on the next cycle.
REQ-010 A stored half of 0 SHALL behave as 1.
REQ-011 OFF SHALL force led = 0; ON SHALL force led = 1; in both modes the phase counter SHALL be held at 0.
REQ-012 BLINK: on each tick, if cnt == half-1 then cnt <= 0 and led toggles, else cnt <= cnt+1; result is a period of 2*half ticks with a 50% duty cycle.
REQ-013 If a write to channel i and a tick occur in the same cycle, the write SHALL win and channel i SHALL ignore that tick; other channels SHALL process the tick normally.
REQ-014 Channels SHALL be independent; a write to one channel SHALL NOT disturb the phase of any other channel.
REQ-015 All outputs SHALL be registered, with no combinational path from inputs to led, tick or cfg_err.

Reset
REQ-016 While rst = 1: prescaler = 0, all modes = OFF, all half = 1, all cnt and phase index = 0, led = 0, tick = 0, cfg_err = 0, cfg_ready = 0.
REQ-017 Assertion of rst mid-pattern SHALL clear all state immediately (asynchronously); the prescaler SHALL restart at 0 on the first edge after deassertion.

Configuration
REQ-018 Macro LED_HEARTBEAT_EN, when defined, SHALL enable HEARTBEAT mode (11):
- 4-phase sequence: led 1 for half ticks, 0 for half, 1 for half, 0 for 5*half, then repeat from phase 0.
- Each phase starts with cnt = 0.
REQ-019 Without LED_HEARTBEAT_EN, mode 11 SHALL be stored but SHALL behave exactly as OFF, and the phase-index logic SHALL not be synthesised.

Verification (CLK_HZ=100, TICK_HZ=10, so DIV=10; N_CH=4)
REQ-020 Release reset -> tick first high on cycle 10 after release, then every 10 cycles; led = 0000 throughout.
REQ-021 Write ch1 BLINK half=3 -> led[1]=1 the cycle after acceptance, toggles every 3 ticks (30 cycles), period 60 cycles; other bits stay 0.
REQ-022 Write ch5 (CH_W=2 so exercise with N_CH=3 and ch=3) -> cfg_err is a one-cycle pulse and led is unchanged.
REQ-023 Write ch0 ON in the same cycle tick=1 while ch0 is BLINK -> led[0]=1 and held; ch2 BLINK continues its toggling unperturbed.
REQ-024 With LED_HEARTBEAT_EN, write ch3 mode 11 half=2 -> led[3] pattern 1,1,0,0,1,1,0×10 in ticks, repeating; without the macro, led[3] stays 0.
REQ-025 Assert rst for 3 cycles mid-BLINK -> led = 0 asynchronously, all modes OFF after release, and a new write restarts cleanly.
